// File: rtl/mmio_led_pwm.sv
// mmio_led_pwm: memory-mapped LED, 3-channel 8-bit PWM and us/ms timers.
// Latency: read_data one cycle after read_address; writes land on the same edge.
// Backpressure: none; every load and store completes without stalling.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   write_enable/_address/_data/_mask   store port (byte enables in write_mask)
//   read_address, read_data             load port (registered data)
//   led, red, green, blue               board outputs, all active-high
//
// Optional feature: define MMIO_TIMERS_EN to build the MICROS/MILLIS counters.
// Without it, offsets 0x10/0x14 read 0 like the reserved offsets.
module mmio_led_pwm #(
  parameter int unsigned CLK_FREQ_HZ  = 12000000,
  parameter logic [31:0] BASE_ADDR    = 32'hFFFFFFE0,
  parameter int unsigned PWM_PRESCALE = 47
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_enable,
  input  logic [31:0] write_address,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_mask,
  input  logic [31:0] read_address,
  output logic [31:0] read_data,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);

  localparam int PRE_W = (PWM_PRESCALE > 0) ? $clog2(PWM_PRESCALE + 1) : 1;

  // Register indices (address[4:2]).
  localparam logic [2:0] IDX_LED    = 3'd0;
  localparam logic [2:0] IDX_DUTY_R = 3'd1;
  localparam logic [2:0] IDX_DUTY_G = 3'd2;
  localparam logic [2:0] IDX_DUTY_B = 3'd3;
`ifdef MMIO_TIMERS_EN
  localparam logic [2:0] IDX_MICROS = 3'd4;
  localparam logic [2:0] IDX_MILLIS = 3'd5;
`endif

  // All writable fields live in byte 0; the rest of the store bus and the
  // byte offset within a word are intentionally ignored.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{write_address[1:0], read_address[1:0],
                             write_data[31:8], write_mask[3:1]};

  logic       w_hit, r_hit;
  logic [2:0] w_idx, r_idx;
  assign w_hit = (write_address[31:5] == BASE_ADDR[31:5]);
  assign r_hit = (read_address[31:5]  == BASE_ADDR[31:5]);
  assign w_idx = write_address[4:2];
  assign r_idx = read_address[4:2];

  logic       led_reg;
  logic [7:0] duty_r_sh, duty_g_sh, duty_b_sh;   // software-visible shadows
  logic [7:0] act_r, act_g, act_b;               // duties in force this period

  // ---------------------------------------------------------------- writes
  always_ff @(posedge clk) begin
    if (reset) begin
      led_reg   <= 1'b0;
      duty_r_sh <= 8'd0;
      duty_g_sh <= 8'd0;
      duty_b_sh <= 8'd0;
    end else if (write_enable && w_hit && write_mask[0]) begin
      case (w_idx)
        IDX_LED:    led_reg   <= write_data[0];
        IDX_DUTY_R: duty_r_sh <= write_data[7:0];
        IDX_DUTY_G: duty_g_sh <= write_data[7:0];
        IDX_DUTY_B: duty_b_sh <= write_data[7:0];
        default: ;  // read-only and reserved offsets ignore stores
      endcase
    end
  end

  assign led = led_reg;

  // ------------------------------------------------------------------- PWM
  logic [PRE_W-1:0] pre_cnt;
  logic [7:0]       pwm_count;
  logic             pre_wrap;
  assign pre_wrap = (pre_cnt == PRE_W'(PWM_PRESCALE));

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt   <= '0;
      pwm_count <= 8'd0;
      act_r     <= 8'd0;
      act_g     <= 8'd0;
      act_b     <= 8'd0;
      red       <= 1'b0;
      green     <= 1'b0;
      blue      <= 1'b0;
    end else begin
      pre_cnt <= pre_wrap ? '0 : pre_cnt + 1'b1;
      if (pre_wrap) begin
        pwm_count <= pwm_count + 8'd1;
        // Shadows only take effect as the count wraps to 0, so a period is
        // always generated from a single duty value.
        if (pwm_count == 8'hFF) begin
          act_r <= duty_r_sh;
          act_g <= duty_g_sh;
          act_b <= duty_b_sh;
        end
      end
      red   <= (pwm_count < act_r);
      green <= (pwm_count < act_g);
      blue  <= (pwm_count < act_b);
    end
  end

  // ---------------------------------------------------------------- timers
`ifdef MMIO_TIMERS_EN
  localparam int unsigned US_DIV = CLK_FREQ_HZ / 1000000;

  logic [31:0] us_div_cnt;
  logic [9:0]  sub_ms_cnt;
  logic [31:0] micros, millis;
  logic        us_tick;
  assign us_tick = (us_div_cnt == 32'(US_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      us_div_cnt <= 32'd0;
      sub_ms_cnt <= 10'd0;
      micros     <= 32'd0;
      millis     <= 32'd0;
    end else begin
      us_div_cnt <= us_tick ? 32'd0 : us_div_cnt + 32'd1;
      if (us_tick) begin
        micros <= micros + 32'd1;
        if (sub_ms_cnt == 10'd999) begin
          sub_ms_cnt <= 10'd0;
          millis     <= millis + 32'd1;
        end else begin
          sub_ms_cnt <= sub_ms_cnt + 10'd1;
        end
      end
    end
  end
`endif

  // ----------------------------------------------------------------- reads
  // The mux sees pre-edge register values, so a read racing a write to the
  // same register returns the old contents.
  logic [31:0] rd_mux;
  always_comb begin
    rd_mux = 32'd0;
    if (r_hit) begin
      case (r_idx)
        IDX_LED:    rd_mux = {31'd0, led_reg};
        IDX_DUTY_R: rd_mux = {24'd0, duty_r_sh};
        IDX_DUTY_G: rd_mux = {24'd0, duty_g_sh};
        IDX_DUTY_B: rd_mux = {24'd0, duty_b_sh};
`ifdef MMIO_TIMERS_EN
        IDX_MICROS: rd_mux = micros;
        IDX_MILLIS: rd_mux = millis;
`endif
        default:    rd_mux = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) read_data <= 32'd0;
    else       read_data <= rd_mux;
  end

endmodule

// File: tb/tb_mmio_led_pwm.sv
// Directed bench for mmio_led_pwm, built with PWM_PRESCALE=0 so one PWM step
// equals one clock and the PWM count can be tracked from edges since reset.
module tb_mmio_led_pwm;

  logic        clk = 1'b0;
  logic        reset;
  logic        write_enable;
  logic [31:0] write_address;
  logic [31:0] write_data;
  logic [3:0]  write_mask;
  logic [31:0] read_address;
  logic [31:0] read_data;
  logic        led, red, green, blue;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;   // rising edges since the last reset release

  mmio_led_pwm #(
    .CLK_FREQ_HZ (12000000),
    .BASE_ADDR   (32'hFFFFFFE0),
    .PWM_PRESCALE(0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .write_enable (write_enable),
    .write_address(write_address),
    .write_data   (write_data),
    .write_mask   (write_mask),
    .read_address (read_address),
    .read_data    (read_data),
    .led          (led),
    .red          (red),
    .green        (green),
    .blue         (blue)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic do_reset();
    write_enable = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    edge_n = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    write_enable  = 1'b1;
    write_address = a;
    write_data    = d;
    write_mask    = m;
    tick();
    write_enable  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    read_address = a;
    tick();
    v = read_data;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    write_enable = 1'b0;
    write_address = 32'h0;
    write_data = 32'h0;
    write_mask = 4'h0;
    read_address = 32'hFFFFFFE0;
    tick();
    tick();
    n_checks++;
    if ({led, red, green, blue} !== 4'b0000 || read_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got led/rgb=%b rd=%h, want 0000 rd=0", {led, red, green, blue}, read_data);
    end
    reset = 1'b0;
    edge_n = 0;
    tick();
    n_checks++;
    if (read_data !== 32'h0 || {led, red, green, blue} !== 4'b0000) begin
      n_fail++;
      $display("FAIL idle_read_led: got rd=%h outs=%b, want rd=0 outs=0000", read_data, {led, red, green, blue});
    end
  endtask

  task automatic test_led();
    logic [31:0] v;
    wr(32'hFFFFFFE0, 32'h00000001, 4'b0001);
    n_checks++;
    if (led !== 1'b1) begin
      n_fail++;
      $display("FAIL led_set: got %b, want 1", led);
    end
    wr(32'hFFFFFFE0, 32'h00000000, 4'b0000);
    n_checks++;
    if (led !== 1'b1) begin
      n_fail++;
      $display("FAIL led_mask0: got %b, want 1", led);
    end
    rd(32'hFFFFFFE0, v);
    n_checks++;
    if (v !== 32'h00000001) begin
      n_fail++;
      $display("FAIL led_readback: got %h, want 00000001", v);
    end
  endtask

  task automatic test_decode();
    logic [31:0] v;
    rd(32'hFFFFFFF8, v);
    n_checks++;
    if (v !== 32'h0) begin
      n_fail++;
      $display("FAIL read_reserved: got %h, want 0", v);
    end
    // LED is 1 here, so a decode that ignored the upper bits would return 1.
    rd(32'h00001000, v);
    n_checks++;
    if (v !== 32'h0) begin
      n_fail++;
      $display("FAIL read_miss: got %h, want 0", v);
    end
    wr(32'h00001004, 32'h00000055, 4'hF);
    rd(32'hFFFFFFE4, v);
    n_checks++;
    if (v !== 32'h0) begin
      n_fail++;
      $display("FAIL write_miss: got %h, want 0", v);
    end
    wr(32'hFFFFFFE8, 32'hFFFFFF33, 4'b0001);
    rd(32'hFFFFFFE8, v);
    n_checks++;
    if (v !== 32'h00000033) begin
      n_fail++;
      $display("FAIL duty_upper_bits: got %h, want 00000033", v);
    end
    wr(32'hFFFFFFEE, 32'h00000044, 4'b0001);
    rd(32'hFFFFFFEC, v);
    n_checks++;
    if (v !== 32'h00000044) begin
      n_fail++;
      $display("FAIL byte_offset_ignored: got %h, want 00000044", v);
    end
  endtask

  task automatic test_pwm();
    int r_err = 0, g_err = 0, b_err = 0;
    int red_p1 = 0, red_p2 = 0, blue_p2 = 0, green_hi = 0;
    logic er, eg, eb;
    do_reset();
    for (int n = 1; n <= 1024; n++) begin
      if (n == 10) begin
        write_enable = 1'b1; write_address = 32'hFFFFFFE4;
        write_data = 32'h80; write_mask = 4'b0001;
        read_address = 32'hFFFFFFE4;
      end else if (n == 11) begin
        write_enable = 1'b1; write_address = 32'hFFFFFFE8;
        write_data = 32'h00; write_mask = 4'b0001;
      end else if (n == 12) begin
        write_enable = 1'b1; write_address = 32'hFFFFFFEC;
        write_data = 32'hFF; write_mask = 4'b0001;
      end else begin
        write_enable = 1'b0;
      end
      tick();
      if (n == 10) begin
        n_checks++;
        if (read_data !== 32'h0) begin
          n_fail++;
          $display("FAIL same_cycle_rw: got %h, want 00000000", read_data);
        end
      end
      if (n == 11) begin
        n_checks++;
        if (read_data !== 32'h00000080) begin
          n_fail++;
          $display("FAIL duty_r_readback: got %h, want 00000080", read_data);
        end
      end
      // Duties take over at the 255->0 wrap on edge 256; outputs lag by one.
      er = (n >= 257) && (((n - 1) % 256) < 128);
      eg = 1'b0;
      eb = (n >= 257) && (((n - 1) % 256) < 255);
      if (red   !== er) r_err++;
      if (green !== eg) g_err++;
      if (blue  !== eb) b_err++;
      if (n <= 256 && red === 1'b1) red_p1++;
      if (n >= 257 && n <= 512 && red === 1'b1) red_p2++;
      if (n >= 257 && n <= 512 && blue === 1'b1) blue_p2++;
      if (green === 1'b1) green_hi++;
    end
    n_checks++;
    if (red_p1 !== 0) begin
      n_fail++;
      $display("FAIL red_before_wrap: got %0d high cycles, want 0", red_p1);
    end
    n_checks++;
    if (red_p2 !== 128) begin
      n_fail++;
      $display("FAIL red_duty80: got %0d high cycles, want 128", red_p2);
    end
    n_checks++;
    if (blue_p2 !== 255) begin
      n_fail++;
      $display("FAIL blue_dutyFF: got %0d high cycles, want 255", blue_p2);
    end
    n_checks++;
    if (green_hi !== 0) begin
      n_fail++;
      $display("FAIL green_duty0: got %0d high cycles, want 0", green_hi);
    end
    n_checks++;
    if (r_err !== 0 || g_err !== 0 || b_err !== 0) begin
      n_fail++;
      $display("FAIL pwm_waveform: got r/g/b mismatching cycles %0d/%0d/%0d, want 0/0/0", r_err, g_err, b_err);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    int hi = 0;
    wr(32'hFFFFFFE0, 32'h1, 4'b0001);
    while (edge_n < 1124) tick();
    n_checks++;
    if ({led, red, blue} !== 3'b111) begin
      n_fail++;
      $display("FAIL pre_reset_outputs: got led/r/b=%b, want 111", {led, red, blue});
    end
    read_address = 32'hFFFFFFE0;
    reset = 1'b1;
    tick();
    n_checks++;
    if ({led, red, green, blue} !== 4'b0000 || read_data !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got outs=%b rd=%h, want 0000 rd=0", {led, red, green, blue}, read_data);
    end
    reset = 1'b0;
    edge_n = 0;
    rd(32'hFFFFFFE4, v);
    n_checks++;
    if (v !== 32'h0) begin
      n_fail++;
      $display("FAIL duty_r_after_reset: got %h, want 0", v);
    end
    rd(32'hFFFFFFEC, v);
    n_checks++;
    if (v !== 32'h0) begin
      n_fail++;
      $display("FAIL duty_b_after_reset: got %h, want 0", v);
    end
    for (int i = 0; i < 300; i++) begin
      tick();
      if (red === 1'b1 || blue === 1'b1) hi++;
    end
    n_checks++;
    if (hi !== 0) begin
      n_fail++;
      $display("FAIL active_duty_cleared: got %0d high cycles, want 0", hi);
    end
  endtask

  task automatic test_timers();
    logic [31:0] v;
    logic [31:0] exp_us, exp_ms;
`ifdef MMIO_TIMERS_EN
    exp_us = 32'd2000;
    exp_ms = 32'd2;
`else
    exp_us = 32'd0;
    exp_ms = 32'd0;
`endif
    do_reset();
    wr(32'hFFFFFFF0, 32'h0000DEAD, 4'hF);
    wr(32'hFFFFFFF8, 32'h0000BEEF, 4'hF);
    while (edge_n < 24000) tick();
    // Data on edge 24001 reflects the counters after 24000 edges.
    rd(32'hFFFFFFF0, v);
    n_checks++;
    if (v !== exp_us) begin
      n_fail++;
      $display("FAIL micros: got %0d, want %0d", v, exp_us);
    end
    rd(32'hFFFFFFF4, v);
    n_checks++;
    if (v !== exp_ms) begin
      n_fail++;
      $display("FAIL millis: got %0d, want %0d", v, exp_ms);
    end
    rd(32'hFFFFFFF8, v);
    n_checks++;
    if (v !== 32'h0) begin
      n_fail++;
      $display("FAIL reserved_write_ignored: got %h, want 0", v);
    end
  endtask

  initial begin
    test_reset();
    test_led();
    test_decode();
    test_pwm();
    test_reset_mid();
    test_timers();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
